soc_system_switch_debounce: RTL and testbench
=============================================

Name: soc_system_switch_debounce

Overview:
- Input-conditioning stage directly upstream of the slide-switch PIO; its debounced output drives the PIO's 10-bit in_port.
- Synchronises raw asynchronous switch pins into clk, debounces each bit independently, and emits per-bit rise/fall strobes.
- Removes contact bounce and metastability before software polls the switch register.

Parameters:
WIDTH, 10, number of switch bits
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range 1..2^CNT_W-1
CNT_W, 20, width of each per-bit stability counter

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
sw_raw  input  WIDTH  raw asynchronous switch pins
sw_db  output  WIDTH  debounced level; connects to PIO in_port
sw_rise  output  WIDTH  one-cycle pulse per bit on accepted 0->1
sw_fall  output  WIDTH  one-cycle pulse per bit on accepted 1->0
sw_changed  output  1  one-cycle pulse, OR of sw_rise|sw_fall
edge_clear  input  WIDTH  per-bit clear of edge_capture (used only with EDGE_CAPTURE_EN)
edge_capture  output  WIDTH  sticky rising-edge flags (EDGE_CAPTURE_EN)
irq  output  1  level interrupt, OR of edge_capture (EDGE_CAPTURE_EN)

Behaviour:
- Reset: sync1, sync2, sw_db, all counters, sw_rise, sw_fall, sw_changed, edge_capture and irq are 0 on the first clk edge with reset=1. Reset is checked before any other logic.
- Synchroniser: two flops per bit (sync1 <= sw_raw, sync2 <= sync1). No logic sits between them.
- Per-bit debounce, evaluated each cycle for bit i:
  - sync2[i] == sw_db[i]: cnt[i] <= 0, so any glitch back to the stable level restarts the count.
  - sync2[i] != sw_db[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - sync2[i] != sw_db[i] and cnt[i] == DEBOUNCE_CYCLES-1: sw_db[i] <= sync2[i], cnt[i] <= 0.
- Latency: a clean input change on sw_raw reaches sw_db exactly DEBOUNCE_CYCLES+2 clk edges later. With DEBOUNCE_CYCLES=1, the change reaches sw_db 3 edges later.
- Strobes:
  - sw_rise[i] and sw_fall[i] are registered and asserted in the same cycle sw_db[i] changes, for exactly one cycle.
  - sw_changed is registered and coincident with them.
  - Multiple bits may strobe in the same cycle.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Bits are fully independent; activity on one bit never affects another bit's counter.
- Reset mid-count: counts are discarded. After reset releases, a held-high input reaches sw_db after the full latency and produces a sw_rise pulse.
- Parameter check: an elaboration-time error is raised if DEBOUNCE_CYCLES == 0 or DEBOUNCE_CYCLES >= 2^CNT_W.

Optional Feature:
EDGE_CAPTURE_EN
- Defined:
  - edge_capture[i] is set on sw_rise[i] and cleared when edge_clear[i]=1.
  - If set and clear occur in the same cycle, set wins.
  - irq = |edge_capture, registered.
- Undefined:
  - edge_capture and irq are tied to 0 and edge_clear is ignored.
  - The port list is identical in both builds.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=10):
1. Reset held 3 cycles with sw_raw=10'h3FF -> all outputs 0 during reset. After release, sw_db=10'h3FF exactly 6 edges later, sw_rise=10'h3FF and sw_changed=1 for one cycle.
2. sw_raw[0] toggles 0->1 for 3 cycles, back to 0 for 1 cycle, then 1 steadily -> no change during the bounce. sw_db[0] rises 6 edges after the final 0->1, with a single sw_rise[0] pulse.
3. sw_db=10'h001, sw_raw goes to 10'h000 -> sw_fall=10'h001 pulse after 6 edges; sw_rise stays 0.
4. Bits 3 and 7 rise simultaneously and bit 5 rises 2 cycles later -> sw_rise=10'h088 in one cycle, then sw_rise=10'h020 2 cycles later.
5. Reset asserted mid-count (cnt=2) on bit 1 -> sw_db[1] stays 0, no strobe. After release, the full 6-edge latency restarts.
6. EDGE_CAPTURE_EN defined: rise on bit 2 -> edge_capture=10'h004, irq=1. edge_clear=10'h004 coincident with a new rise on bit 2 -> stays set. Clear alone -> edge_capture=0, irq=0 next cycle.

Source files
------------

// File: rtl/soc_system_switch_debounce.sv
// soc_system_switch_debounce
// Conditions the raw slide-switch pins before they reach the switch PIO:
// each bit is brought into clk through a two-flop synchroniser, then
// debounced independently, and accepted level changes are reported as
// one-cycle rise/fall strobes.
//
// Optional feature macro: EDGE_CAPTURE_EN
//   defined   : sticky rising-edge capture flags plus a level irq
//   undefined : edge_capture/irq are held at 0, edge_clear is ignored
//   The port list is the same in both builds.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : synchronous, active-high reset
//   sw_raw       : raw asynchronous switch pins
//   sw_db        : debounced level (feeds the PIO in_port)
//   sw_rise      : one-cycle pulse per bit on an accepted 0->1
//   sw_fall      : one-cycle pulse per bit on an accepted 1->0
//   sw_changed   : one-cycle pulse, OR of all rise/fall strobes
//   edge_clear   : per-bit clear of edge_capture
//   edge_capture : sticky rising-edge flags
//   irq          : OR of edge_capture
module soc_system_switch_debounce #(
    parameter int unsigned WIDTH           = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed,
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] edge_capture,
    output logic             irq
);

    // Terminal count: the D-th consecutive differing sample accepts the level.
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Reject thresholds the counter cannot represent.
    if (DEBOUNCE_CYCLES == 0 ||
        64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_W)) begin : g_bad_param
        $error("DEBOUNCE_CYCLES must be in 1..2^CNT_W-1");
    end

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic             irq_q, irq_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Synchroniser, per-bit debounce counters and strobe generation.
    always_comb begin
        sync1_d = sw_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            // Matching the accepted level (or accepting) restarts the count.
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i]   = sync2_q[i];
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        changed_d = |(rise_d | fall_d);
    end

`ifdef EDGE_CAPTURE_EN
    // Sticky rising-edge flags; a new rise beats a same-cycle clear.
    always_comb begin
        cap_d = (cap_q & ~edge_clear) | rise_d;
        irq_d = |cap_d;
    end
`else
    logic unused_edge_clear;
    assign unused_edge_clear = ^edge_clear;

    always_comb begin
        cap_d = '0;
        irq_d = 1'b0;
    end
`endif

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            cap_q     <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            cap_q     <= cap_d;
            irq_q     <= irq_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_db        = db_q;
    assign sw_rise      = rise_q;
    assign sw_fall      = fall_q;
    assign sw_changed   = changed_q;
    assign edge_capture = cap_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_soc_system_switch_debounce.sv
// Self-checking bench for soc_system_switch_debounce (WIDTH=10, DEBOUNCE_CYCLES=4).
// Reference model: a level is accepted when the last D synchronised samples
// since reset all differ from the current debounced level.
module tb_soc_system_switch_debounce;

    localparam int unsigned W = 10;
    localparam int unsigned D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_db;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_changed;
    logic [W-1:0] edge_clear;
    logic [W-1:0] edge_capture;
    logic         irq;

    soc_system_switch_debounce #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sw_raw(sw_raw),
        .sw_db(sw_db),
        .sw_rise(sw_rise),
        .sw_fall(sw_fall),
        .sw_changed(sw_changed),
        .edge_clear(edge_clear),
        .edge_capture(edge_capture),
        .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0] m_s1, m_s2, m_db, m_rise, m_fall, m_cap;
    logic         m_irq;
    logic [W-1:0] hist[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [W-1:0] raw, input logic rst, input logic [W-1:0] clr);
        logic all_diff;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0;
            m_cap = '0; m_irq = 1'b0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > D) void'(hist.pop_front());
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                if (hist.size() == D) begin
                    all_diff = 1'b1;
                    foreach (hist[k]) if (hist[k][i] == m_db[i]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_db[i] = ~m_db[i];
                        if (m_db[i]) m_rise[i] = 1'b1;
                        else         m_fall[i] = 1'b1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
`ifdef EDGE_CAPTURE_EN
            m_cap = (m_cap & ~clr) | m_rise;
            m_irq = |m_cap;
`else
            m_cap = '0;
            m_irq = 1'b0;
            if (clr != clr) m_irq = 1'b1;
`endif
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit after posedge, compare to model.
    task automatic step(input logic [W-1:0] raw, input logic rst, input logic [W-1:0] clr);
        @(negedge clk);
        sw_raw     = raw;
        reset      = rst;
        edge_clear = clr;
        @(posedge clk);
        #1;
        model_edge(raw, rst, clr);
        check("sw_db",        32'(sw_db),        32'(m_db));
        check("sw_rise",      32'(sw_rise),      32'(m_rise));
        check("sw_fall",      32'(sw_fall),      32'(m_fall));
        check("sw_changed",   32'(sw_changed),   32'(|(m_rise | m_fall)));
        check("edge_capture", 32'(edge_capture), 32'(m_cap));
        check("irq",          32'(irq),          32'(m_irq));
    endtask

    // Hold raw and count edges until sw_db matches want (bounded).
    task automatic measure_latency(input string tag, input logic [W-1:0] raw,
                                   input logic [W-1:0] want, input int exp_edges);
        int n = 0;
        do begin
            step(raw, 1'b0, '0);
            n++;
        end while (sw_db !== want && n < 30);
        check(tag, 32'(n), 32'(exp_edges));
    endtask

    logic [W-1:0] cur;

    initial begin
        sw_raw = '0; reset = 1'b1; edge_clear = '0;

        // 1: reset with all switches high, then full latency and rise burst.
        for (int i = 0; i < 3; i++) begin
            step(10'h3FF, 1'b1, '0);
            check("rst_outputs", 32'({sw_db, sw_rise, sw_fall, sw_changed, edge_capture, irq}), 32'd0);
        end
        measure_latency("lat_after_reset", 10'h3FF, 10'h3FF, D + 2);
        check("rise_burst", 32'(sw_rise), 32'h3FF);
        check("changed_burst", 32'(sw_changed), 32'd1);
        step(10'h3FF, 1'b0, '0);
        check("rise_one_cycle", 32'(sw_rise), 32'd0);

        // Return to all-low.
        for (int i = 0; i < 8; i++) step(10'h000, 1'b0, '0);
        check("all_low", 32'(sw_db), 32'd0);

        // 2: bounce on bit 0, then settle high.
        for (int i = 0; i < 3; i++) step(10'h001, 1'b0, '0);
        step(10'h000, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(10'h000, 1'b0, '0);
        check("bounce_no_change", 32'(sw_db), 32'd0);
        measure_latency("lat_bounce", 10'h001, 10'h001, D + 2);
        check("bounce_rise", 32'(sw_rise), 32'h001);

        // 3: fall of bit 0.
        measure_latency("lat_fall", 10'h000, 10'h000, D + 2);
        check("fall_pulse", 32'(sw_fall), 32'h001);
        check("fall_no_rise", 32'(sw_rise), 32'd0);

        // 4: bits 3,7 together, bit 5 two cycles later.
        step(10'h088, 1'b0, '0);
        step(10'h088, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(10'h0A8, 1'b0, '0);
        step(10'h0A8, 1'b0, '0);
        check("rise_3_7", 32'(sw_rise), 32'h088);
        step(10'h0A8, 1'b0, '0);
        step(10'h0A8, 1'b0, '0);
        check("rise_5", 32'(sw_rise), 32'h020);

        // 5: reset mid-count on bit 1.
        for (int i = 0; i < 4; i++) step(10'h002, 1'b0, '0);
        step(10'h002, 1'b1, '0);
        check("midcount_reset_db", 32'(sw_db), 32'd0);
        measure_latency("lat_after_midreset", 10'h002, 10'h002, D + 2);
        check("midreset_rise", 32'(sw_rise), 32'h002);

`ifdef EDGE_CAPTURE_EN
        // 6: edge capture set, set-beats-clear, clear alone.
        for (int i = 0; i < 8; i++) step(10'h000, 1'b0, '0);
        measure_latency("lat_cap", 10'h004, 10'h004, D + 2);
        check("cap_set", 32'(edge_capture), 32'h004);
        check("irq_set", 32'(irq), 32'd1);
        for (int i = 0; i < 8; i++) step(10'h000, 1'b0, 10'h004);
        check("cap_cleared", 32'(edge_capture), 32'd0);
        for (int i = 0; i < D + 1; i++) step(10'h004, 1'b0, '0);
        step(10'h004, 1'b0, 10'h004);
        check("cap_set_wins", 32'(edge_capture), 32'h004);
        step(10'h004, 1'b0, 10'h004);
        check("cap_clear", 32'(edge_capture), 32'd0);
        check("irq_clear", 32'(irq), 32'd0);
`endif

        // Randomized segments: held levels of random length with bounce and clears.
        cur = '0;
        for (int seg = 0; seg < 400; seg++) begin
            int len;
            logic rst;
            cur ^= W'($urandom) & W'($urandom) & W'($urandom);
            len = int'($urandom_range(1, 10));
            rst = ($urandom_range(0, 60) == 0);
            for (int c = 0; c < len; c++) begin
                step(cur, rst && (c == 0), W'($urandom) & W'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
